// File: rtl/spi_master_cfg_pkg.sv
// Shared types for the SPI master: mode encoding, FSM states and a sizing helper.
package spi_master_cfg_pkg;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam spi_mode_t SPI_MODE0 = 2'b00;
    localparam spi_mode_t SPI_MODE1 = 2'b01;
    localparam spi_mode_t SPI_MODE2 = 2'b10;
    localparam spi_mode_t SPI_MODE3 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_DONE
    } spi_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_master_cfg_if.sv
// Host-side request/response bundle for spi_master_cfg.
interface spi_master_cfg_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4
);
    import spi_master_cfg_pkg::*;

    localparam int CS_W = clog2_min1(NUM_CS);

    logic              start;
    logic [DATA_W-1:0] data_in;
    logic [CS_W-1:0]   cs_sel;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic [DATA_W-1:0] data_out;
    logic              done;
    logic              busy;

    modport master (
        output start, data_in, cs_sel, cpol, cpha, lsb_first,
        input  data_out, done, busy
    );

    modport slave (
        input  start, data_in, cs_sel, cpol, cpha, lsb_first,
        output data_out, done, busy
    );

endinterface

// File: rtl/spi_master_cfg_sclk_gen.sv
// SCLK generator: CLK_DIV phase counter, edge strobe with leading/trailing flag, owns sclk.
module spi_sclk_gen
    import spi_master_cfg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic xfer,
    input  logic load,
    input  logic cpol_in,
    input  logic cpol,
    output logic tick,
    output logic edge_stb,
    output logic leading,
    output logic sclk
);
    localparam int                CNT_W    = clog2_min1(CLK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick     = run && (cnt == CNT_LAST);
    assign edge_stb = tick && xfer;
    assign leading  = (sclk == cpol);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (!run || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Idle level follows the most recently accepted cpol until the next transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sclk <= 1'b0;
        else if (load)
            sclk <= cpol_in;
        else if (edge_stb)
            sclk <= ~sclk;
    end

endmodule

// File: rtl/spi_master_cfg.sv
// Parametrised SPI master, all four CPOL/CPHA modes, MSB/LSB order, one-hot-low chip selects.
// Optional build macro SPI_MASTER_LOOPBACK_EN adds a loopback input that samples internal mosi.
module spi_master_cfg
    import spi_master_cfg_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_CS  = 4,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    spi_master_cfg_if.slave   host,
    input  logic              miso,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] cs_n
);
    localparam int                CS_W     = clog2_min1(NUM_CS);
    localparam int                BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [CS_W:0]     CS_LIMIT = (CS_W + 1)'(NUM_CS);

    spi_state_t        state, state_nxt;
    spi_mode_t         mode;
    logic              lsb_l;
    logic [CS_W-1:0]   cs_l;
    logic [DATA_W-1:0] tx_sh, rx_sh, data_out_q;
    logic [BIT_W-1:0]  bit_cnt;
    logic              mosi_q;
    logic              accept, run, in_xfer, done_o;
    logic              tick, edge_stb, leading, last_bit, drive, sample, rx_bit;

    function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    assign accept   = (state == ST_IDLE) && host.start && ({1'b0, host.cs_sel} < CS_LIMIT);
    assign run      = (state == ST_SETUP) || (state == ST_XFER) || (state == ST_HOLD);
    assign in_xfer  = (state == ST_XFER);
    assign last_bit = (bit_cnt == BIT_LAST);
    // cpha=0 drives on trailing edges only between bits; cpha=1 drives on every leading edge.
    assign drive    = edge_stb && (mode.cpha ? leading : (!leading && !last_bit));
    assign sample   = edge_stb && (mode.cpha != leading);

`ifdef SPI_MASTER_LOOPBACK_EN
    assign rx_bit = loopback ? mosi_q : miso;
`else
    assign rx_bit = miso;
`endif

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run),
        .xfer     (in_xfer),
        .load     (accept),
        .cpol_in  (host.cpol),
        .cpol     (mode.cpol),
        .tick     (tick),
        .edge_stb (edge_stb),
        .leading  (leading),
        .sclk     (sclk)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (accept) state_nxt = ST_SETUP;
            ST_SETUP: if (tick) state_nxt = ST_XFER;
            ST_XFER:  if (edge_stb && !leading && last_bit) state_nxt = ST_HOLD;
            ST_HOLD:  if (tick) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cs_n   = '1;
        done_o = (state == ST_DONE);
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (run && (cs_l == CS_W'(i)))
                cs_n[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode       <= SPI_MODE0;
            lsb_l      <= 1'b0;
            cs_l       <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            bit_cnt    <= '0;
            mosi_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            if (accept) begin
                mode    <= '{cpol: host.cpol, cpha: host.cpha};
                lsb_l   <= host.lsb_first;
                cs_l    <= host.cs_sel;
                rx_sh   <= '0;
                bit_cnt <= '0;
                // tx_sh always holds the not-yet-driven bits at its output end.
                if (host.cpha) begin
                    tx_sh  <= host.data_in;
                    mosi_q <= 1'b0;
                end else begin
                    tx_sh  <= shift_out(host.data_in, host.lsb_first);
                    mosi_q <= head_bit(host.data_in, host.lsb_first);
                end
            end
            if (drive) begin
                mosi_q <= head_bit(tx_sh, lsb_l);
                tx_sh  <= shift_out(tx_sh, lsb_l);
            end
            if (sample)
                rx_sh <= lsb_l ? {rx_bit, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], rx_bit};
            if (edge_stb && !leading)
                bit_cnt <= bit_cnt + 1'b1;
            if ((state == ST_HOLD) && tick) begin
                data_out_q <= rx_sh;
                mosi_q     <= 1'b0;
            end
        end
    end

    assign mosi          = mosi_q;
    assign host.data_out = data_out_q;
    assign host.done     = done_o;
    assign host.busy     = run;

endmodule
